ecc_engine_arbiter: RTL and testbench
=====================================

ECC_ENGINE_ARBITER -- requirements
Module: ecc_engine_arbiter

Interface
REQ-001 SHALL have parameter: ECC_W, 164, point/scalar field width.
REQ-002 SHALL have parameter: TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with ECC_ARB_TIMEOUT_EN).
REQ-003 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: n_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: req_a, req_b  in  1  level requests from requester A (key generation) and B (shared secret).
REQ-006 SHALL have ports: k_a, px_a, py_a, k_b, px_b, py_b  in  ECC_W  scalar and base point per requester.
REQ-007 SHALL have port: estart  out  1  single-cycle engine start pulse.
REQ-008 SHALL have ports: ek, epx, epy  out  ECC_W  registered operands to the engine.
REQ-009 SHALL have ports: edone  in  1, and erx, ery  in  ECC_W; edone is the engine completion strobe, erx/ery its result.
REQ-010 SHALL have ports: done_a, done_b  out  1  single-cycle completion pulses per requester.
REQ-011 SHALL have ports: res_x, res_y  out  ECC_W  registered result, shared by both requesters.
REQ-012 SHALL have ports: busy  out  1, owner  out  1 (0=A, 1=B), err  out  1 (timeout flag).

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-014 IDLE: no request -> stay in IDLE; any request -> latch the winner's k/px/py into ek/epx/epy, set owner, go to LOAD.
REQ-015 Arbitration SHALL be two-way round robin: on simultaneous requests, grant the requester not served last; after reset, A has priority.
REQ-016 LOAD: estart=1 for exactly this cycle, then go to RUN.
REQ-017 RUN: on edone=1, capture erx/ery into res_x/res_y and go to DONE; otherwise stay in RUN.
REQ-018 DONE: pulse done_a or done_b per owner for one cycle, record last-served, go to IDLE.
REQ-019 Latency: a request sampled in IDLE at edge N gives estart high in cycle N+1; an edone sampled at edge M gives the done pulse in cycle M+1.
REQ-020 busy SHALL be 1 in LOAD, RUN and DONE, and 0 in IDLE.
REQ-021 edone SHALL be ignored outside RUN.
REQ-022 Request inputs and operands SHALL be ignored outside IDLE; ek/epx/epy stay stable from LOAD until the next grant.
REQ-023 A req dropped mid-operation SHALL NOT abort it; the done pulse and result are still produced.
REQ-024 A req still high in the IDLE cycle after DONE is a new request, arbitrated normally.
REQ-025 res_x/res_y SHALL hold until the next capture.

Reset
REQ-026 n_rst=0 SHALL immediately force state IDLE, last-served=B, and set to 0: estart, done_a, done_b, busy, owner, err, ek, epx, epy, res_x, res_y.
REQ-027 Reset during RUN SHALL abandon the operation with no done pulse.

Configuration
REQ-028 With ECC_ARB_TIMEOUT_EN defined: a counter cleared on entering RUN increments each RUN cycle; reaching TIMEOUT_CYC-1 without edone goes to DONE, sets res_x/res_y=0 and err=1, and still pulses the owner's done; err clears on the next grant.
REQ-029 With ECC_ARB_TIMEOUT_EN undefined: no counter exists, err is tied to 0, and RUN waits for edone indefinitely.

Structure
REQ-030 Package ecc_arb_pkg SHALL hold the ECC_W constant, the state enum (IDLE/LOAD/RUN/DONE) and the owner enum (OWN_A/OWN_B).
REQ-031 The watchdog counter SHALL be sub-module ecc_arb_wdog, instantiated only under ECC_ARB_TIMEOUT_EN.

Verification
REQ-032 Single-request flow: req_a=1 with k_a=5 and px_a/py_a=G; edone after 10 cycles with erx=0x1234 -> estart pulses once, done_a pulses once, res_x=0x1234, done_b stays 0.
REQ-033 Simultaneous requests: req_a=req_b=1 held after reset -> grant order A, B, A, B; owner alternates on each done pulse.
REQ-034 Spurious edone: edone=1 in IDLE and in LOAD -> no state change, no done pulse, res_x/res_y unchanged.
REQ-035 Reset in RUN: n_rst=0 three cycles after estart -> all outputs 0 at once, and no done pulse after release.
REQ-036 Timeout (macro on, TIMEOUT_CYC=16): no edone -> done_b pulses 16 cycles after entering RUN with err=1 and res_x=0; err clears on the next grant.
REQ-037 Dropped request: req_b deasserted in RUN -> done_b still pulses and res holds the engine result.

Source files
------------

// File: rtl/ecc_arb_pkg.sv
// Shared types for the ECC engine arbiter: field width, FSM states, owner encoding.
package ecc_arb_pkg;

  localparam int ECC_W = 164;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} arb_state_e;

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;

endpackage

// File: rtl/ecc_arb_if.sv
// Requester and engine handshake bundle for the ECC engine arbiter.
// master = requesters plus engine; slave = the arbiter itself.
interface ecc_arb_if #(parameter int W = ecc_arb_pkg::ECC_W);

  logic         req_a;
  logic         req_b;
  logic [W-1:0] k_a;
  logic [W-1:0] px_a;
  logic [W-1:0] py_a;
  logic [W-1:0] k_b;
  logic [W-1:0] px_b;
  logic [W-1:0] py_b;
  logic         estart;
  logic [W-1:0] ek;
  logic [W-1:0] epx;
  logic [W-1:0] epy;
  logic         edone;
  logic [W-1:0] erx;
  logic [W-1:0] ery;
  logic         done_a;
  logic         done_b;
  logic [W-1:0] res_x;
  logic [W-1:0] res_y;
  logic         busy;
  logic         owner;
  logic         err;

  modport master (
    output req_a, req_b, k_a, px_a, py_a, k_b, px_b, py_b, edone, erx, ery,
    input  estart, ek, epx, epy, done_a, done_b, res_x, res_y, busy, owner, err
  );

  modport slave (
    input  req_a, req_b, k_a, px_a, py_a, k_b, px_b, py_b, edone, erx, ery,
    output estart, ek, epx, epy, done_a, done_b, res_x, res_y, busy, owner, err
  );

endinterface

// File: rtl/ecc_arb_wdog.sv
// Watchdog counter for the arbiter RUN state; used only when ECC_ARB_TIMEOUT_EN is defined.
module ecc_arb_wdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT_CYC - 1));

  // Saturates at the limit so a stalled RUN never wraps back to zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ecc_engine_arbiter.sv
// Two-way round-robin arbiter sharing one ECC point-multiply engine between requesters A and B.
// Optional RUN watchdog enabled by defining ECC_ARB_TIMEOUT_EN.
module ecc_engine_arbiter
  import ecc_arb_pkg::*;
#(
  parameter int ECC_W       = ecc_arb_pkg::ECC_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic      clk,
  input  logic      n_rst,
  ecc_arb_if.slave  bus
);

  arb_state_e state;
  owner_e     last_served;
  logic       grant_b;
  logic       wdog_expired;

  // B wins when it is the only requester, or when both ask and A was served last.
  assign grant_b = bus.req_b & (~bus.req_a | (last_served == OWN_A));

`ifdef ECC_ARB_TIMEOUT_EN
  logic err_q;

  ecc_arb_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (state == LOAD),
    .en      (state == RUN),
    .expired (wdog_expired)
  );

  assign bus.err = err_q;
`else
  assign wdog_expired = 1'b0;
  assign bus.err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      last_served <= OWN_B;
      bus.estart  <= 1'b0;
      bus.done_a  <= 1'b0;
      bus.done_b  <= 1'b0;
      bus.busy    <= 1'b0;
      bus.owner   <= 1'b0;
      bus.ek      <= '0;
      bus.epx     <= '0;
      bus.epy     <= '0;
      bus.res_x   <= '0;
      bus.res_y   <= '0;
`ifdef ECC_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      bus.estart <= 1'b0;
      bus.done_a <= 1'b0;
      bus.done_b <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            state      <= LOAD;
            bus.busy   <= 1'b1;
            bus.estart <= 1'b1;
            bus.owner  <= grant_b;
            bus.ek     <= grant_b ? bus.k_b  : bus.k_a;
            bus.epx    <= grant_b ? bus.px_b : bus.px_a;
            bus.epy    <= grant_b ? bus.py_b : bus.py_a;
`ifdef ECC_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          // A real completion takes precedence over a watchdog expiry in the same cycle.
          if (bus.edone) begin
            state      <= DONE;
            bus.res_x  <= bus.erx;
            bus.res_y  <= bus.ery;
            bus.done_a <= ~bus.owner;
            bus.done_b <= bus.owner;
          end else if (wdog_expired) begin
            state      <= DONE;
            bus.res_x  <= '0;
            bus.res_y  <= '0;
            bus.done_a <= ~bus.owner;
            bus.done_b <= bus.owner;
`ifdef ECC_ARB_TIMEOUT_EN
            err_q      <= 1'b1;
`endif
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          last_served <= owner_e'(bus.owner);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_engine_arbiter.sv
// Randomized self-checking bench for ecc_engine_arbiter against a transaction-level model.
// Define ECC_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC=16).
module tb_ecc_engine_arbiter;
  import ecc_arb_pkg::*;

  localparam int W = 164;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   passes = 0;

  bit            grant_log[$];
  logic [W-1:0]  res_mx;
  logic [W-1:0]  res_my;

  always #5 clk = ~clk;

  ecc_arb_if #(.W(W)) bus ();

  ecc_engine_arbiter #(.ECC_W(W), .TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: A if only A, B if only B; on a tie the one not in the last completed slot (B before any).
  function automatic bit predict(input bit ra, input bit rb);
    if (ra && rb) return (grant_log.size() == 0) ? 1'b0 : !grant_log[$];
    return rb;
  endfunction

  task automatic applyStimulus();
    bus.k_a  = rand_word();
    bus.px_a = rand_word();
    bus.py_a = rand_word();
    bus.k_b  = rand_word();
    bus.px_b = rand_word();
    bus.py_b = rand_word();
  endtask

  task automatic run_txn(input bit ra, input bit rb, input int delay, input bit drop,
                         input bit spurious, input logic [W-1:0] rx, input logic [W-1:0] ry);
    bit           own;
    logic [W-1:0] xk, xpx, xpy;
    own = predict(ra, rb);
    xk  = own ? bus.k_b  : bus.k_a;
    xpx = own ? bus.px_b : bus.px_a;
    xpy = own ? bus.py_b : bus.py_a;
    bus.req_a = ra;
    bus.req_b = rb;
    step();
    checkOutput("load_estart", bus.estart, 1);
    checkOutput("load_busy", bus.busy, 1);
    checkOutput("load_owner", bus.owner, own);
    checkOutput("load_ek", bus.ek, xk);
    checkOutput("load_epx", bus.epx, xpx);
    checkOutput("load_epy", bus.epy, xpy);
    checkOutput("grant_err", bus.err, 0);
    if (drop) begin
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
    end
    applyStimulus();
    if (spurious) begin
      bus.edone = 1'b1;
      bus.erx   = rand_word();
      bus.ery   = rand_word();
    end
    step();
    bus.edone = 1'b0;
    checkOutput("run_estart", bus.estart, 0);
    checkOutput("run_res_x", bus.res_x, res_mx);
    checkOutput("run_ek_stable", bus.ek, xk);
    for (int i = 0; i < delay; i++) begin
      step();
      checkOutput("run_no_done", {bus.done_a, bus.done_b}, 0);
    end
    bus.edone = 1'b1;
    bus.erx   = rx;
    bus.ery   = ry;
    step();
    bus.edone = 1'b0;
    res_mx = rx;
    res_my = ry;
    checkOutput("done_a", bus.done_a, !own);
    checkOutput("done_b", bus.done_b, own);
    checkOutput("done_res_x", bus.res_x, res_mx);
    checkOutput("done_res_y", bus.res_y, res_my);
    checkOutput("done_busy", bus.busy, 1);
    step();
    checkOutput("idle_busy", bus.busy, 0);
    checkOutput("idle_done", {bus.done_a, bus.done_b}, 0);
    checkOutput("idle_epx_hold", bus.epx, xpx);
    grant_log.push_back(own);
  endtask

  task automatic idle_spurious();
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.edone = 1'b1;
    bus.erx   = rand_word();
    bus.ery   = rand_word();
    step();
    bus.edone = 1'b0;
    checkOutput("sp_busy", bus.busy, 0);
    checkOutput("sp_estart", bus.estart, 0);
    checkOutput("sp_done", {bus.done_a, bus.done_b}, 0);
    checkOutput("sp_res_x", bus.res_x, res_mx);
    checkOutput("sp_res_y", bus.res_y, res_my);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    bit ra, rb;
    n_rst     = 1'b0;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.edone = 1'b0;
    bus.erx   = '0;
    bus.ery   = '0;
    applyStimulus();
    res_mx = '0;
    res_my = '0;
    #12;
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_estart", bus.estart, 0);
    checkOutput("rst_owner", bus.owner, 0);
    checkOutput("rst_ek", bus.ek, 0);
    checkOutput("rst_res_x", bus.res_x, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_done", {bus.done_a, bus.done_b}, 0);
    step();
    n_rst = 1'b1;
    step();

    // Single A request with fixed operands and a ten-cycle engine.
    applyStimulus();
    bus.k_a = 164'd5;
    run_txn(1, 0, 9, 0, 0, 164'h1234, rand_word());
    checkOutput("single_res_x", bus.res_x, 164'h1234);

    // Both held high from a fresh reset: A, B, A, B.
    step();
    n_rst = 1'b0;
    #1;
    n_rst = 1'b1;
    grant_log.delete();
    res_mx = '0;
    res_my = '0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      run_txn(1, 1, $urandom_range(0, 4), 0, 1, rand_word(), rand_word());
      checkOutput("rr_order", grant_log[$], (i % 2));
    end

    idle_spurious();

    // Dropped B request still completes.
    applyStimulus();
    run_txn(0, 1, 3, 1, 0, rand_word(), rand_word());

    // Reset three cycles after estart abandons the operation.
    applyStimulus();
    bus.req_a = 1'b1;
    step();
    checkOutput("rr_estart", bus.estart, 1);
    bus.req_a = 1'b0;
    step();
    step();
    step();
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("arst_busy", bus.busy, 0);
    checkOutput("arst_ek", bus.ek, 0);
    checkOutput("arst_res_x", bus.res_x, 0);
    checkOutput("arst_owner", bus.owner, 0);
    step();
    n_rst = 1'b1;
    grant_log.delete();
    res_mx = '0;
    res_my = '0;
    for (int i = 0; i < 5; i++) begin
      bus.edone = 1'b1;
      step();
      checkOutput("arst_no_done", {bus.done_a, bus.done_b, bus.busy}, 0);
    end
    bus.edone = 1'b0;

`ifdef ECC_ARB_TIMEOUT_EN
    // Engine never answers: watchdog ends the B operation with err set.
    applyStimulus();
    bus.req_b = 1'b1;
    step();
    checkOutput("to_estart", bus.estart, 1);
    bus.req_b = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      step();
      checkOutput("to_wait", {bus.done_a, bus.done_b}, 0);
    end
    step();
    checkOutput("to_done_b", bus.done_b, 1);
    checkOutput("to_err", bus.err, 1);
    checkOutput("to_res_x", bus.res_x, 0);
    step();
    grant_log.push_back(1'b1);
    res_mx = '0;
    res_my = '0;
`endif

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idle_spurious();
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (!ra && !rb) ra = 1'b1;
      applyStimulus();
      run_txn(ra, rb, $urandom_range(0, 8), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), rand_word(), rand_word());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
